// File: rtl/mux_scan_pkg.sv
// Shared types and widths for the scan serializer and its 16:1 select tree.
package mux_scan_pkg;
  localparam int SEL_W  = 4;
  localparam int WORD_W = 16;

  localparam logic [SEL_W-1:0] CNT_MAX = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/mux16to1.sv
// Purely combinational 16:1 select: four 4:1 muxes on sel[1:0], then one 4:1 on sel[3:2].
module mux16to1
  import mux_scan_pkg::*;
(
  input  logic [WORD_W-1:0] d,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  logic [3:0] lvl1;

  function automatic logic mux4(input logic [3:0] v, input logic [1:0] k);
    return v[k];
  endfunction

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      lvl1[g] = mux4(d[4*g +: 4], sel[1:0]);
    end
    y = mux4(lvl1, sel[3:2]);
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Loads a 16-bit word over a ready/load handshake and shifts it out one bit per clock
// through the 16:1 select tree, with registered valid/last qualifiers.
module mux_scan_serializer
  import mux_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [WORD_W-1:0] w,
  input  logic              load,
  input  logic              clr,
  output logic              ready,
  output logic [SEL_W-1:0]  s,
  output logic              f,
  output logic              fvalid,
  output logic              last
);

  // Handshake: a word is taken on a rising edge where load=1 and ready=1.
  // ready is high in IDLE or on the final bit of a scan, and always low while clr=1.

  state_t             state, state_next;
  logic [SEL_W-1:0]   cnt, cnt_next;
  logic [WORD_W-1:0]  hold, hold_next;
  logic               f_next, fvalid_next, last_next;
  logic               mux_bit;
  logic               accept;
  logic               scan_end;

  assign scan_end = (state == SCAN) && (cnt == CNT_MAX);
  assign ready    = !clr && ((state == IDLE) || scan_end);
  assign accept   = load && ready;
  assign s        = MSB_FIRST ? (CNT_MAX - cnt) : cnt;

  mux16to1 u_mux (
    .d   (hold),
    .sel (s),
    .y   (mux_bit)
  );

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    hold_next   = hold;
    f_next      = f;
    fvalid_next = fvalid;
    last_next   = last;
    if (clr) begin
      // Abort keeps hold and f; only the control state is cleared.
      state_next  = IDLE;
      cnt_next    = '0;
      fvalid_next = 1'b0;
      last_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fvalid_next = 1'b0;
          last_next   = 1'b0;
          if (accept) begin
            hold_next  = w;
            cnt_next   = '0;
            state_next = SCAN;
          end
        end
        SCAN: begin
          f_next      = mux_bit;
          fvalid_next = 1'b1;
          last_next   = (cnt == CNT_MAX);
          cnt_next    = cnt + 1'b1;
          if (scan_end) begin
            if (accept) begin
              hold_next = w;
              cnt_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      hold   <= '0;
      f      <= 1'b0;
      fvalid <= 1'b0;
      last   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      hold   <= hold_next;
      f      <= f_next;
      fvalid <= fvalid_next;
      last   <= last_next;
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: one instance per scan order, shared stimulus.
module tb_mux_scan_serializer;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] w;
  logic        load;
  logic        clr;

  logic       ready0, f0, fvalid0, last0;
  logic [3:0] s0;
  logic       ready1, f1, fvalid1, last1;
  logic [3:0] s1;

  int vectors     = 0;
  int miscompares = 0;

  logic [0:0] exp_q[$];

  // Bit i of each constant is the i-th serial bit expected for w=16'hA5C3.
  logic [15:0] seq_lsb;
  logic [15:0] seq_msb;

  mux_scan_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .w(w), .load(load), .clr(clr),
    .ready(ready0), .s(s0), .f(f0), .fvalid(fvalid0), .last(last0)
  );

  mux_scan_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .w(w), .load(load), .clr(clr),
    .ready(ready1), .s(s1), .f(f1), .fvalid(fvalid1), .last(last1)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_word(input logic [15:0] word);
    w    = word;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (ready0 !== 1'b1 || s0 !== 4'd0 || f0 !== 1'b0 || fvalid0 !== 1'b0 || last0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b s=%0d f=%b fvalid=%b last=%b, need 1 0 0 0 0",
               ready0, s0, f0, fvalid0, last0);
    end
    vectors++;
    if (ready1 !== 1'b1 || f1 !== 1'b0 || fvalid1 !== 1'b0 || last1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs_msb: got ready=%b f=%b fvalid=%b last=%b, need 1 0 0 0",
               ready1, f1, fvalid1, last1);
    end
  endtask

  task automatic test_scan_lsb();
    logic [0:0] e;
    logic [3:0] es;
    load_word(16'hA5C3);
    vectors++;
    if (fvalid0 !== 1'b0 || ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL lsb_accept: got fvalid=%b ready=%b, need 0 0", fvalid0, ready0);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(seq_lsb[i]);
    for (int i = 0; i < 16; i++) begin
      tick();
      e  = exp_q.pop_front();
      es = 4'(i + 1);
      vectors++;
      if (f0 !== e[0] || fvalid0 !== 1'b1 || last0 !== (i == 15) || s0 !== es || ready0 !== (i >= 14)) begin
        miscompares++;
        $display("FAIL lsb_bit%0d: got f=%b fvalid=%b last=%b s=%0d ready=%b, need %b 1 %b %0d %b",
                 i, f0, fvalid0, last0, s0, ready0, e[0], (i == 15), es, (i >= 14));
      end
    end
    tick();
    vectors++;
    if (fvalid0 !== 1'b0 || last0 !== 1'b0 || ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL lsb_idle: got fvalid=%b last=%b ready=%b, need 0 0 1", fvalid0, last0, ready0);
    end
  endtask

  task automatic test_scan_msb();
    logic [0:0] e;
    logic [3:0] es;
    load_word(16'hA5C3);
    vectors++;
    if (s1 !== 4'd15) begin
      miscompares++;
      $display("FAIL msb_first_sel: got s=%0d, need 15", s1);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(seq_msb[i]);
    for (int i = 0; i < 16; i++) begin
      tick();
      e  = exp_q.pop_front();
      es = 4'd15 - 4'(i + 1);
      vectors++;
      if (f1 !== e[0] || fvalid1 !== 1'b1 || last1 !== (i == 15) || s1 !== es) begin
        miscompares++;
        $display("FAIL msb_bit%0d: got f=%b fvalid=%b last=%b s=%0d, need %b 1 %b %0d",
                 i, f1, fvalid1, last1, s1, e[0], (i == 15), es);
      end
    end
    tick();
    vectors++;
    if (fvalid1 !== 1'b0 || ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL msb_idle: got fvalid=%b ready=%b, need 0 1", fvalid1, ready1);
    end
  endtask

  task automatic test_back_to_back();
    w    = 16'hFFFF;
    load = 1'b1;
    tick();
    w = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      tick();
      vectors++;
      if (f0 !== (i < 16) || fvalid0 !== 1'b1 || last0 !== (i == 15 || i == 31)) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: got f=%b fvalid=%b last=%b, need %b 1 %b",
                 i, f0, fvalid0, last0, (i < 16), (i == 15 || i == 31));
      end
      if (i == 15) load = 1'b0;
    end
    tick();
    vectors++;
    if (fvalid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got fvalid=%b, need 0", fvalid0);
    end
  endtask

  task automatic test_load_ignored();
    load_word(16'hA5C3);
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (f0 !== seq_lsb[i] || fvalid0 !== 1'b1) begin
        miscompares++;
        $display("FAIL ignore_bit%0d: got f=%b fvalid=%b, need %b 1", i, f0, fvalid0, seq_lsb[i]);
      end
      if (i == 4) begin
        vectors++;
        if (ready0 !== 1'b0) begin
          miscompares++;
          $display("FAIL ignore_ready_cnt5: got %b, need 0", ready0);
        end
        load = 1'b1;
        w    = 16'h1234;
      end
      if (i == 5) load = 1'b0;
    end
    tick();
    vectors++;
    if (fvalid0 !== 1'b0 || ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_idle: got fvalid=%b ready=%b, need 0 1", fvalid0, ready0);
    end
  endtask

  task automatic test_clr();
    load_word(16'hA5C3);
    for (int i = 0; i < 7; i++) tick();
    clr  = 1'b1;
    load = 1'b1;
    w    = 16'hFFFF;
    tick();
    // f keeps bit 6 of the aborted word, which is 1.
    vectors++;
    if (fvalid0 !== 1'b0 || last0 !== 1'b0 || ready0 !== 1'b0 || s0 !== 4'd0 || f0 !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_edge: got fvalid=%b last=%b ready=%b s=%0d f=%b, need 0 0 0 0 1",
               fvalid0, last0, ready0, s0, f0);
    end
    clr  = 1'b0;
    load = 1'b0;
    #1;
    vectors++;
    if (ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_ready: got %b, need 1", ready0);
    end
    tick();
    vectors++;
    if (fvalid0 !== 1'b0 || f0 !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_no_word: got fvalid=%b f=%b, need 0 1", fvalid0, f0);
    end
    load_word(16'hA5C3);
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (f0 !== seq_lsb[i] || fvalid0 !== 1'b1 || last0 !== (i == 15)) begin
        miscompares++;
        $display("FAIL clr_reload_bit%0d: got f=%b fvalid=%b last=%b, need %b 1 %b",
                 i, f0, fvalid0, last0, seq_lsb[i], (i == 15));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    load_word(16'hA5C3);
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (fvalid0 !== 1'b1 || s0 !== 4'd3) begin
      miscompares++;
      $display("FAIL rst_pre: got fvalid=%b s=%0d, need 1 3", fvalid0, s0);
    end
    #3;
    Resetn = 1'b0;
    #1;
    vectors++;
    if (f0 !== 1'b0 || fvalid0 !== 1'b0 || last0 !== 1'b0 || s0 !== 4'd0 || ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_async: got f=%b fvalid=%b last=%b s=%0d ready=%b, need 0 0 0 0 1",
               f0, fvalid0, last0, s0, ready0);
    end
    #2;
    Resetn = 1'b1;
    tick();
    vectors++;
    if (fvalid0 !== 1'b0 || last0 !== 1'b0 || ready0 !== 1'b1 || s0 !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_after: got fvalid=%b last=%b ready=%b s=%0d, need 0 0 1 0",
               fvalid0, last0, ready0, s0);
    end
  endtask

  initial begin
    seq_lsb = 16'b1010_0101_1100_0011;
    seq_msb = 16'b1100_0011_1010_0101;
    Resetn  = 1'b0;
    w       = 16'h0000;
    load    = 1'b0;
    clr     = 1'b0;
    #12;
    test_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    test_scan_lsb();
    test_scan_msb();
    test_back_to_back();
    test_load_ignored();
    test_clr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
